// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 asynchronous serial receiver.
//
// Deserialises rxd (idle high, start 0, 8 data bits LSB first, stop 1) into
// bytes. Each completed frame raises rdata_ready for one clock, at which point
// rdata holds the byte and ferr is set if the stop bit sampled low. Both hold
// until the next completed frame.
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-high reset
//   rxd         serial input, asynchronous to clk
//   rdata       last received byte
//   rdata_ready one-cycle strobe: rdata/ferr updated this cycle
//   ferr        framing error of the last completed frame
module uart_receiver #(
    parameter int CLK_PER_HALF_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rdata_ready,
    output logic       ferr
);

    localparam int CW = $clog2(2 * CLK_PER_HALF_BIT) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(2 * CLK_PER_HALF_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            ferr_q, ferr_d;
    logic            rdata_ready_q, rdata_ready_d;

    // Two-flop synchroniser; both stages reset to the idle level.
    logic            rx_meta_q;
    logic            rxs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rdata_q       <= '0;
            ferr_q        <= 1'b0;
            rdata_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            rdata_q       <= rdata_d;
            ferr_q        <= ferr_d;
            rdata_ready_q <= rdata_ready_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        rdata_d       = rdata_q;
        ferr_d        = ferr_q;
        rdata_ready_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end

            START: begin
                // Re-check the line half a bit after the falling edge so
                // short low glitches are rejected.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    // Shift in from the top: after eight samples the first
                    // received bit sits in bit 0.
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            STOP: begin
                // The mid-stop sample is registered straight into the
                // outputs, so they appear on the edge after the sample.
                // Returning to IDLE mid-stop-bit lets back-to-back frames
                // with a single stop bit through.
                if (cnt_q == BIT_LAST) begin
                    cnt_d         = '0;
                    rdata_d       = shift_q;
                    ferr_d        = ~rxs_q;
                    rdata_ready_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign rdata       = rdata_q;
    assign ferr        = ferr_q;
    assign rdata_ready = rdata_ready_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized and directed frames for uart_receiver,
// checked against a frame-level reference queue (byte, expected ferr,
// start-edge cycle) filled by the line driver.
module tb_uart_receiver;

    localparam int H   = 30;
    localparam int BIT = 2 * H;
    localparam int LAT = 19 * H + 3;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] rdata;
    logic       rdata_ready;
    logic       ferr;

    uart_receiver #(.CLK_PER_HALF_BIT(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .rdata       (rdata),
        .rdata_ready (rdata_ready),
        .ferr        (ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        ferr;
        int unsigned start;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic        prev_ready = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Frame monitor: every strobe must match the oldest outstanding frame.
    always @(negedge clk) begin
        exp_t        e;
        int unsigned lat;
        if (prev_ready) check_eq("ready_width", rdata_ready, 0);
        if (rdata_ready) begin
            check_eq("strobe_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                lat = cyc - e.start;
                check_eq("rdata", rdata, e.data);
                check_eq("ferr", ferr, e.ferr);
                check_eq("latency_window", (lat + 1 >= LAT) && (lat <= LAT + 1), 1);
            end
        end
        prev_ready = rdata_ready;
    end

    task automatic idle_bits(input int n);
        repeat (n * BIT) @(posedge clk);
    endtask

    task automatic hold_bit(input logic lvl);
        #1 rxd = lvl;
        repeat (BIT) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        exp_t e;
        @(posedge clk);
        #1 rxd = 1'b0;
        e.data  = b;
        e.ferr  = ~stop_lvl;
        e.start = cyc;
        exp_q.push_back(e);
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop_lvl);
        #1 rxd = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        logic       s;
        exp_t       e;

        rst = 1'b1;
        rxd = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_eq("reset_rdata", rdata, 0);
        check_eq("reset_ready", rdata_ready, 0);
        check_eq("reset_ferr", ferr, 0);
        rst = 1'b0;
        idle_bits(1);

        // Single clean frame.
        send_frame(8'hAA, 1'b1);
        idle_bits(1);

        // Back-to-back frames, one stop bit each.
        send_frame(8'h55, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_bits(1);

        // Framing error then a clean frame.
        send_frame(8'h3C, 1'b0);
        idle_bits(2);
        send_frame(8'h41, 1'b1);
        idle_bits(1);

        // Short low glitch while idle: no strobe expected.
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (10) @(posedge clk);
        #1 rxd = 1'b1;
        idle_bits(3);
        send_frame(8'h7E, 1'b1);
        idle_bits(1);

        // Reset in the middle of data bit 4: partial frame discarded.
        b = 8'hE5;
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 4; i++) hold_bit(b[i]);
        #1 rxd = b[4];
        repeat (H) @(posedge clk);
        #1 rst = 1'b1;
        rxd = 1'b1;
        #2;
        check_eq("midrst_rdata", rdata, 0);
        check_eq("midrst_ferr", ferr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_bits(12);
        check_eq("postrst_rdata", rdata, 0);
        send_frame(8'hC3, 1'b1);
        idle_bits(1);

        // Spaced stream.
        send_frame(8'h50, 1'b1);
        repeat (3000) @(posedge clk);
        send_frame(8'h33, 1'b1);
        repeat (3000) @(posedge clk);
        send_frame(8'h0A, 1'b1);
        idle_bits(2);

        // Line held low long enough for exactly one frame: 0x00 with ferr.
        @(posedge clk);
        #1 rxd = 1'b0;
        e.data  = 8'h00;
        e.ferr  = 1'b1;
        e.start = cyc;
        exp_q.push_back(e);
        repeat (19 * H + 10) @(posedge clk);
        #1 rxd = 1'b1;
        idle_bits(3);

        // Randomized frames with occasional bad stop bits and random gaps.
        for (int n = 0; n < 40; n++) begin
            b = 8'($urandom);
            s = ($urandom_range(0, 7) != 0);
            send_frame(b, s);
            if (!s) idle_bits(2);
            else    idle_bits(int'($urandom_range(0, 2)));
        end

        // Bounded drain of outstanding frames.
        for (int i = 0; i < 4 * BIT && exp_q.size() != 0; i++) @(posedge clk);
        idle_bits(1);
        check_eq("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
